exp_share_arbiter: RTL

- Shares one exponent FSMD (a^n, 8-bit operands, 16-bit result, go/done handshake) between NUM_REQ requesters.
- Arbitration is round-robin.
- Per job: latches the winner's operands, pulses go, waits for done, returns the result with a one-cycle ack.
- A watchdog aborts hung jobs and resets the unit.
- Sits between client logic (e.g. display/LCD sequencer, test drivers) and either exponent datapath variant.

---
 rtl/exp_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 29 ++
 rtl/exp_share_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/exp_arb_pkg.sv
// Shared types and widths for the exponent-unit arbiter.
package exp_arb_pkg;
  localparam int OPW  = 8;
  localparam int RESW = 16;
  localparam int CNTW = 16;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RECOVER, RESP} state_t;

  // Watchdog count must stick at all-ones rather than wrap.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     id,
  output logic               valid
);
  int             idx;
  logic [IDW-1:0] sel;

  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = 0;
    sel   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IDW'(idx);
      if (!valid && req[sel]) begin
        valid = 1'b1;
        id    = sel;
      end
    end
  end
endmodule

// File: rtl/exp_share_arbiter.sv
// Round-robin share of one a^n unit between NUM_REQ requesters, with watchdog.
// Optional macro EXP_ARB_CYCLE_CNT_EN adds cycles_o (WAIT-cycle count of acked job).
//
// state   | meaning
// IDLE    | waiting for any request, grant picked here
// ISSUE   | go pulse to the unit, watchdog cleared
// WAIT    | waiting for a rising edge of done_i or watchdog expiry
// RECOVER | reset pulse to a hung unit
// RESP    | one-cycle ack (with err on abort) to the granted requester
module exp_share_arbiter
  import exp_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [OPW*NUM_REQ-1:0] n_req_i,
  input  logic [OPW*NUM_REQ-1:0] a_req_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [RESW-1:0]        result_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic                   go_o,
  output logic [OPW-1:0]         n_o,
  output logic [OPW-1:0]         a_o,
  output logic                   unit_rst_o,
`ifdef EXP_ARB_CYCLE_CNT_EN
  output logic [CNTW-1:0]        cycles_o,
`endif
  input  logic                   done_i,
  input  logic [RESW-1:0]        result_i
);
  localparam int IDW = $clog2(NUM_REQ);

  state_t          r_state, w_state_nx;
  logic [IDW-1:0]  r_ptr, w_ptr_nx;
  logic [IDW-1:0]  r_id, w_id_nx;
  logic            r_err, w_err_nx;
  logic [CNTW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic            r_done_q;

  logic [NUM_REQ-1:0] w_ack_nx;
  logic [RESW-1:0]    w_result_nx;
  logic [OPW-1:0]     w_n_nx, w_a_nx;
  logic               w_err_o_nx, w_go_nx, w_busy_nx, w_unit_rst_nx;
  logic [IDW-1:0]     w_gnt_id;
  logic               w_gnt_valid;
  logic               w_done_rise;
`ifdef EXP_ARB_CYCLE_CNT_EN
  logic [CNTW-1:0]    w_cycles_nx;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr_pick (
    .req   (req_i),
    .ptr   (r_ptr),
    .id    (w_gnt_id),
    .valid (w_gnt_valid)
  );

  assign w_done_rise = done_i && !r_done_q;
  assign w_cnt_inc   = sat_inc(r_cnt);

  always_comb begin
    w_state_nx  = r_state;
    w_ptr_nx    = r_ptr;
    w_id_nx     = r_id;
    w_err_nx    = r_err;
    w_cnt_nx    = r_cnt;
    w_n_nx      = n_o;
    w_a_nx      = a_o;
    w_result_nx = result_o;
`ifdef EXP_ARB_CYCLE_CNT_EN
    w_cycles_nx = cycles_o;
`endif
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_nx = ISSUE;
          w_id_nx    = w_gnt_id;
          w_ptr_nx   = w_gnt_id;
          for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_id == IDW'(k)) begin
              w_n_nx = n_req_i[k*OPW +: OPW];
              w_a_nx = a_req_i[k*OPW +: OPW];
            end
          end
        end
      end
      ISSUE: begin
        w_cnt_nx   = '0;
        w_state_nx = WAIT;
      end
      WAIT: begin
        if (w_done_rise) begin
          w_result_nx = result_i;
          w_state_nx  = RESP;
`ifdef EXP_ARB_CYCLE_CNT_EN
          w_cycles_nx = w_cnt_inc;
`endif
        end else begin
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc == CNTW'(TIMEOUT)) begin
            w_result_nx = '0;
            w_err_nx    = 1'b1;
            w_state_nx  = RECOVER;
          end
        end
      end
      RECOVER: begin
        w_state_nx = RESP;
`ifdef EXP_ARB_CYCLE_CNT_EN
        w_cycles_nx = r_cnt;
`endif
      end
      RESP: begin
        w_err_nx   = 1'b0;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    w_go_nx       = (w_state_nx == ISSUE);
    w_busy_nx     = (w_state_nx != IDLE);
    w_unit_rst_nx = (w_state_nx == RECOVER);
    w_err_o_nx    = (w_state_nx == RESP) ? w_err_nx : 1'b0;
    w_ack_nx      = '0;
    if (w_state_nx == RESP) w_ack_nx[w_id_nx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= IDW'(NUM_REQ - 1);
      r_id       <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_done_q   <= 1'b0;
      ack_o      <= '0;
      result_o   <= '0;
      err_o      <= 1'b0;
      busy_o     <= 1'b0;
      go_o       <= 1'b0;
      n_o        <= '0;
      a_o        <= '0;
      unit_rst_o <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_ptr      <= w_ptr_nx;
      r_id       <= w_id_nx;
      r_err      <= w_err_nx;
      r_cnt      <= w_cnt_nx;
      r_done_q   <= done_i;
      ack_o      <= w_ack_nx;
      result_o   <= w_result_nx;
      err_o      <= w_err_o_nx;
      busy_o     <= w_busy_nx;
      go_o       <= w_go_nx;
      n_o        <= w_n_nx;
      a_o        <= w_a_nx;
      unit_rst_o <= w_unit_rst_nx;
    end
  end

`ifdef EXP_ARB_CYCLE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycles_o <= '0;
    else     cycles_o <= w_cycles_nx;
  end
`endif
endmodule
